cnn_add_skip_align: RTL and testbench
=====================================

// Module: cnn_add_skip_align
// PURPOSE
// FP32 element-wise adder for residual/skip joins. The skip stream (no2) arrives
// early and is held in a parametrised FIFO. Each main-stream (no1) element pops
// one skip element and goes through a pipelined FP add, with run-time selectable
// add/sub/ReLU/bypass modes. Counts elements per frame, flags frame end, and
// reports FIFO overflow/underflow.
// PARAMETERS
// DATA_WIDTH   32       element width (IEEE-754 single)
// FIFO_DEPTH   1024     skip FIFO depth; power of 2, >= max no2-to-no1 lead
// FRAME_SIZE   612*612  elements per frame (per output channel plane)
// ADD_LATENCY  4        cycles from accepted pair to valid_out (FP add core latency)
// PORTS
// clk           in   1           rising-edge clock
// reset         in   1           asynchronous, active-low reset
// mode          in   2           00 a+b, 01 a-b, 10 relu(a+b), 11 bypass a
// valid_in_no1  in   1           main-stream element valid
// in_no1        in   DATA_WIDTH  main-stream element (a)
// valid_in_no2  in   1           skip-stream element valid
// in_no2        in   DATA_WIDTH  skip-stream element (b)
// out           out  DATA_WIDTH  result
// valid_out     out  1           result valid, 1-cycle pulse per result
// frame_last    out  1           high with valid_out on element FRAME_SIZE-1 of frame
// fifo_level    out  clog2(FIFO_DEPTH)+1  skip elements currently buffered
// err_overflow  out  1           sticky: no2 element dropped (FIFO full)
// err_underflow out  1           sticky: no1 element dropped (FIFO empty)
// BEHAVIOUR
// - reset low: all outputs 0, FIFO empty, frame counter 0, pipeline valids cleared.
//   Asserting reset mid-frame discards in-flight data; no valid_out for it later.
// - Push: valid_in_no2 & !full -> write in_no2; valid_in_no2 & full -> drop,
//   set err_overflow.
// - Pair accept: valid_in_no1 & (!empty | push this cycle is NOT used) -> pop head.
//   No same-cycle bypass: an element pushed in cycle t is poppable from t+1.
//   valid_in_no1 & empty -> drop a, set err_underflow, frame count unchanged.
// - Simultaneous push+pop when full: pop frees a slot, push accepted; level unchanged.
//   Simultaneous push+pop when empty: push accepted, a dropped (underflow).
// - fifo_level registered, updates the cycle after push/pop; range 0..FIFO_DEPTH.
// - mode sampled at pair accept and carried with the pair, so a mid-stream change
//   never affects in-flight results.
// - Operand prep (combinational before core): 00 b as-is; 01 b sign bit inverted;
//   10 b as-is; 11 b forced to 0x00000000 (note -0 + +0 gives +0).
// - Core: FP add; result exactly ADD_LATENCY cycles after accept (accept in cycle t ->
//   valid_out in t+ADD_LATENCY). Throughput 1 pair/cycle, no back-pressure.
// - ReLU (mode 10): result sign bit 1 -> out = 0x00000000; else result unchanged.
// - Sideband (mode, frame_last) in a shift register of ADD_LATENCY matching the core.
// - Frame counter increments per accepted pair; at FRAME_SIZE-1 tags frame_last and
//   wraps to 0. Dropped elements never count.
// - Error flags clear only on reset.
// TESTING
// - T1 mode 00: push 0x40000000 (2.0), then no1 0x3F800000 (1.0) -> 0x40400000 (3.0)
//   ADD_LATENCY cycles after accept; fifo_level 1->0.
// - T2 mode 01 and 10: a=1.0,b=2.0 -> mode 01 0xBF800000 (-1.0); mode 10 same
//   pair with b=-2.0 (0xC0000000) -> 0x00000000.
// - T3 FIFO_DEPTH=4: push 5 with no no1 -> level 4, err_overflow=1, 5th dropped;
//   then 4 no1 pops return the first 4 in order.
// - T4 no1 on empty FIFO -> no valid_out, err_underflow=1; push+no1 in same cycle
//   on empty -> also underflow, pushed element kept (level 1).
// - T5 FRAME_SIZE=6: 13 back-to-back pairs -> frame_last on results 6 and 12,
//   continuous valid_out; mode toggled mid-stream only changes later pairs.
// - T6 reset low with 3 results in flight -> outputs 0 at once, no stale valid_out
//   after release, level 0, counter restarts (frame_last on 6th new pair).

Source files
------------

// File: rtl/cnn_add_skip_align.sv
// FP32 element-wise adder for residual joins: buffers the early skip stream in a FIFO and
// adds each main-stream element to the FIFO head through a fixed-latency pipeline.
module cnn_add_skip_align #(
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 1024,
  parameter int FRAME_SIZE  = 612*612,
  parameter int ADD_LATENCY = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    mode,
  input  logic                          valid_in_no1,
  input  logic [DATA_WIDTH-1:0]         in_no1,
  input  logic                          valid_in_no2,
  input  logic [DATA_WIDTH-1:0]         in_no2,
  output logic [DATA_WIDTH-1:0]         out,
  output logic                          valid_out,
  output logic                          frame_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_overflow,
  output logic                          err_underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
  localparam int PD = ADD_LATENCY - 1;
  localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_SIZE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // IEEE-754 single add, round-to-nearest-even, subnormals handled, canonical quiet NaN.
  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] big, sml, res;
    logic [9:0]  e_big, e_sml, e_res, shamt;
    logic [26:0] m_big, m_sml, m_shf, mask;
    logic [27:0] sum;
    logic [24:0] rnd;
    logic [4:0]  lz;
    logic        found;
    big = x; sml = y; res = 32'h0000_0000;
    e_big = 10'd0; e_sml = 10'd0; e_res = 10'd0; shamt = 10'd0;
    m_big = 27'd0; m_sml = 27'd0; m_shf = 27'd0; mask = 27'd0;
    sum = 28'd0; rnd = 25'd0; lz = 5'd0; found = 1'b0;
    if ((x[30:23] == 8'hFF && x[22:0] != 23'd0) || (y[30:23] == 8'hFF && y[22:0] != 23'd0)) begin
      res = 32'h7FC0_0000;
    end else if (x[30:23] == 8'hFF && y[30:23] == 8'hFF && x[31] != y[31]) begin
      res = 32'h7FC0_0000;
    end else if (x[30:23] == 8'hFF) begin
      res = x;
    end else if (y[30:23] == 8'hFF) begin
      res = y;
    end else begin
      if (x[30:0] < y[30:0]) begin
        big = y; sml = x;
      end else begin
        big = x; sml = y;
      end
      e_big = (big[30:23] == 8'd0) ? 10'd1 : {2'b00, big[30:23]};
      e_sml = (sml[30:23] == 8'd0) ? 10'd1 : {2'b00, sml[30:23]};
      m_big = {(big[30:23] != 8'd0), big[22:0], 3'b000};
      m_sml = {(sml[30:23] != 8'd0), sml[22:0], 3'b000};
      shamt = e_big - e_sml;
      if (shamt >= 10'd27) begin
        m_shf = {26'd0, (m_sml != 27'd0)};
      end else begin
        mask  = (27'd1 << shamt) - 27'd1;
        m_shf = (m_sml >> shamt) | {26'd0, |(m_sml & mask)};
      end
      if (big[31] == sml[31]) sum = {1'b0, m_big} + {1'b0, m_shf};
      else                    sum = {1'b0, m_big} - {1'b0, m_shf};
      e_res = e_big;
      if (sum == 28'd0) begin
        res = {big[31] & sml[31], 31'd0};
      end else begin
        if (sum[27]) begin
          sum   = {1'b0, sum[27:2], sum[1] | sum[0]};
          e_res = e_res + 10'd1;
        end else begin
          for (int i = 26; i >= 0; i--) begin
            if (!found) begin
              if (sum[i]) found = 1'b1;
              else        lz = lz + 5'd1;
            end
          end
          // Normalisation stops at the subnormal exponent floor.
          shamt = e_res - 10'd1;
          if ({5'd0, lz} > shamt) lz = shamt[4:0];
          sum   = sum << lz;
          e_res = e_res - {5'd0, lz};
        end
        rnd = {1'b0, sum[26:3]} + {24'd0, sum[2] & (sum[1] | sum[0] | sum[3])};
        if (rnd[24]) begin
          rnd   = {1'b0, rnd[24:1]};
          e_res = e_res + 10'd1;
        end
        if (e_res >= 10'd255) res = {big[31], 8'hFF, 23'd0};
        else                  res = {big[31], (rnd[23] ? e_res[7:0] : 8'd0), rnd[22:0]};
      end
    end
    fp_add = res;
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]         level_r;
  logic                  full_s, empty_s, push_s, pop_s, last_s;
  logic [DATA_WIDTH-1:0] head_s, b_prep_s, sum_s, res_s;
  logic [CW-1:0]         frame_cnt_r;
  logic                  ovf_r, udf_r;
  logic                  vld_a_r, last_a_r;
  logic [1:0]            mode_a_r;
  logic [DATA_WIDTH-1:0] a_r, b_r;
  logic [DATA_WIDTH-1:0] res_pipe_r [PD];
  logic [PD-1:0]         vld_pipe_r, last_pipe_r;

  // A pop in the same cycle frees the slot a full-FIFO push needs; an empty FIFO never pops.
  assign full_s  = (level_r == DEPTH_L);
  assign empty_s = (level_r == {LW{1'b0}});
  assign pop_s   = valid_in_no1 & ~empty_s;
  assign push_s  = valid_in_no2 & (~full_s | pop_s);
  assign head_s  = mem_r[rd_ptr_r];
  assign last_s  = (frame_cnt_r == LAST_IDX);

  // Skip-element storage.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= in_no2;
  end

  // FIFO pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
      ovf_r <= ovf_r | (valid_in_no2 & ~push_s);
      udf_r <= udf_r | (valid_in_no1 & empty_s);
    end
  end

  // Operand prep on the popped skip element.
  always_comb begin
    b_prep_s = head_s;
    case (mode)
      2'b01:   b_prep_s = {~head_s[DATA_WIDTH-1], head_s[DATA_WIDTH-2:0]};
      2'b11:   b_prep_s = {DATA_WIDTH{1'b0}};
      default: b_prep_s = head_s;
    endcase
  end

  // Frame position counter and accept stage; mode and frame tag travel with the pair.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt_r <= {CW{1'b0}};
      vld_a_r     <= 1'b0;
      last_a_r    <= 1'b0;
      mode_a_r    <= 2'b00;
      a_r         <= {DATA_WIDTH{1'b0}};
      b_r         <= {DATA_WIDTH{1'b0}};
    end else begin
      vld_a_r <= pop_s;
      if (pop_s) begin
        frame_cnt_r <= last_s ? {CW{1'b0}} : frame_cnt_r + CNT_ONE;
        last_a_r    <= last_s;
        mode_a_r    <= mode;
        a_r         <= in_no1;
        b_r         <= b_prep_s;
      end
    end
  end

  assign sum_s = fp_add(a_r, b_r);
  assign res_s = (mode_a_r == 2'b10 && sum_s[DATA_WIDTH-1]) ? {DATA_WIDTH{1'b0}} : sum_s;

  // Result pipeline; its last stage drives the outputs directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PD; i++) res_pipe_r[i] <= {DATA_WIDTH{1'b0}};
      vld_pipe_r  <= {PD{1'b0}};
      last_pipe_r <= {PD{1'b0}};
    end else begin
      res_pipe_r[0]  <= res_s;
      vld_pipe_r[0]  <= vld_a_r;
      last_pipe_r[0] <= vld_a_r & last_a_r;
      for (int i = 1; i < PD; i++) begin
        res_pipe_r[i]  <= res_pipe_r[i-1];
        vld_pipe_r[i]  <= vld_pipe_r[i-1];
        last_pipe_r[i] <= last_pipe_r[i-1];
      end
    end
  end

  assign out           = res_pipe_r[PD-1];
  assign valid_out     = vld_pipe_r[PD-1];
  assign frame_last    = last_pipe_r[PD-1];
  assign fifo_level    = level_r;
  assign err_overflow  = ovf_r;
  assign err_underflow = udf_r;

endmodule

// File: tb/tb_cnn_add_skip_align.sv
// Scoreboard bench for cnn_add_skip_align: directed pairs queue expected results,
// an independent monitor checks value, frame tag and arrival cycle of every output.
module tb_cnn_add_skip_align;
  localparam int LAT = 4;
  localparam logic [31:0] F0  = 32'h0000_0000, F1 = 32'h3F80_0000, F2 = 32'h4000_0000;
  localparam logic [31:0] F3  = 32'h4040_0000, F4 = 32'h4080_0000, F5 = 32'h40A0_0000;
  localparam logic [31:0] F6  = 32'h40C0_0000, F8 = 32'h4100_0000, FM1 = 32'hBF80_0000;
  localparam logic [31:0] FM2 = 32'hC000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic        valid_in_no1, valid_in_no2, valid_out, frame_last, err_overflow, err_underflow;
  logic [31:0] in_no1, in_no2, out;
  logic [2:0]  fifo_level;

  typedef struct { logic [31:0] data; logic last; int cyc; } exp_t;
  exp_t sb_q[$];
  int cyc = 0;
  int checks = 0;
  int passed = 0;

  cnn_add_skip_align #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .FRAME_SIZE(6), .ADD_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .valid_in_no1(valid_in_no1), .in_no1(in_no1),
    .valid_in_no2(valid_in_no2), .in_no2(in_no2),
    .out(out), .valid_out(valid_out), .frame_last(frame_last),
    .fifo_level(fifo_level), .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every valid_out must match the oldest expectation, including arrival cycle.
  always @(negedge clk) begin
    if (valid_out) begin
      checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_valid_out: got out=%h at cyc %0d, required no output", out, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (out !== e.data || frame_last !== e.last || cyc != e.cyc)
          $display("FAIL result: got out=%h last=%b cyc=%0d, required out=%h last=%b cyc=%0d",
                   out, frame_last, cyc, e.data, e.last, e.cyc);
        else passed++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h, required %h", name, act, exp);
    else passed++;
  endtask

  // One input cycle; an expected result is queued for LAT cycles after the accept edge.
  task automatic step(input logic v1, input logic [31:0] a, input logic v2, input logic [31:0] b,
                      input logic [1:0] md, input logic exp_out, input logic [31:0] ev, input logic el);
    exp_t e;
    valid_in_no1 = v1; in_no1 = a; valid_in_no2 = v2; in_no2 = b; mode = md;
    if (exp_out) begin
      e.data = ev; e.last = el; e.cyc = cyc + LAT;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    valid_in_no1 = 1'b0; valid_in_no2 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, F0, 1'b0, F0, 2'b00, 1'b0, F0, 1'b0);
  endtask

  task automatic pair(input logic [1:0] md, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ev, input logic el);
    step(1'b0, F0, 1'b1, b, md, 1'b0, F0, 1'b0);
    step(1'b1, a, 1'b0, F0, md, 1'b1, ev, el);
  endtask

  task automatic do_reset();
    idle(8);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    int w;
    valid_in_no1 = 1'b0; valid_in_no2 = 1'b0; in_no1 = F0; in_no2 = F0; mode = 2'b00;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid_out", {31'd0, valid_out}, 32'd0);
    check("reset_out", out, F0);
    check("reset_level", {29'd0, fifo_level}, 32'd0);
    check("reset_errs", {30'd0, err_overflow, err_underflow}, 32'd0);
    reset = 1'b1;

    // T1: 1.0 + 2.0 with level 1 -> 0
    step(1'b0, F0, 1'b1, F2, 2'b00, 1'b0, F0, 1'b0);
    check("t1_level_after_push", {29'd0, fifo_level}, 32'd1);
    step(1'b1, F1, 1'b0, F0, 2'b00, 1'b1, F3, 1'b0);
    check("t1_level_after_pop", {29'd0, fifo_level}, 32'd0);

    // T2: sub, relu, bypass of -0, unequal exponents, cancellation, frame tag on 6th pair
    do_reset();
    pair(2'b01, F1, F2, FM1, 1'b0);
    pair(2'b10, F1, FM2, F0, 1'b0);
    pair(2'b11, 32'h8000_0000, F2, F0, 1'b0);
    pair(2'b00, 32'h3FC0_0000, 32'h3E80_0000, 32'h3FE0_0000, 1'b0);
    pair(2'b00, F2, FM2, F0, 1'b0);
    pair(2'b10, F5, F1, F6, 1'b1);

    // T3: overflow on 5th push, push+pop while full, order preserved
    do_reset();
    step(1'b0, F0, 1'b1, F1, 2'b00, 1'b0, F0, 1'b0);
    step(1'b0, F0, 1'b1, F2, 2'b00, 1'b0, F0, 1'b0);
    step(1'b0, F0, 1'b1, F3, 2'b00, 1'b0, F0, 1'b0);
    check("t3_no_overflow_yet", {31'd0, err_overflow}, 32'd0);
    step(1'b0, F0, 1'b1, F4, 2'b00, 1'b0, F0, 1'b0);
    step(1'b0, F0, 1'b1, F5, 2'b00, 1'b0, F0, 1'b0);
    check("t3_level_full", {29'd0, fifo_level}, 32'd4);
    check("t3_overflow", {31'd0, err_overflow}, 32'd1);
    step(1'b1, F0, 1'b1, F8, 2'b00, 1'b1, F1, 1'b0);
    check("t3_level_push_pop_full", {29'd0, fifo_level}, 32'd4);
    step(1'b1, F0, 1'b0, F0, 2'b00, 1'b1, F2, 1'b0);
    step(1'b1, F0, 1'b0, F0, 2'b00, 1'b1, F3, 1'b0);
    step(1'b1, F0, 1'b0, F0, 2'b00, 1'b1, F4, 1'b0);
    step(1'b1, F0, 1'b0, F0, 2'b00, 1'b1, F8, 1'b0);
    check("t3_level_drained", {29'd0, fifo_level}, 32'd0);
    check("t3_no_underflow", {31'd0, err_underflow}, 32'd0);

    // T4: underflow drops a; push+pop on empty keeps the pushed element
    do_reset();
    step(1'b1, F1, 1'b0, F0, 2'b00, 1'b0, F0, 1'b0);
    check("t4_underflow", {31'd0, err_underflow}, 32'd1);
    check("t4_level_empty", {29'd0, fifo_level}, 32'd0);
    do_reset();
    check("t4_underflow_cleared", {31'd0, err_underflow}, 32'd0);
    step(1'b1, F1, 1'b1, F2, 2'b00, 1'b0, F0, 1'b0);
    check("t4_underflow_same_cycle", {31'd0, err_underflow}, 32'd1);
    check("t4_level_kept", {29'd0, fifo_level}, 32'd1);
    step(1'b1, F1, 1'b0, F0, 2'b00, 1'b1, F3, 1'b0);
    check("t4_no_overflow", {31'd0, err_overflow}, 32'd0);

    // T5: 13 back-to-back pairs, mode switches to subtract from pair 7
    do_reset();
    step(1'b0, F0, 1'b1, F2, 2'b00, 1'b0, F0, 1'b0);
    for (int i = 0; i < 13; i++)
      step(1'b1, F1, (i < 12), F2, (i < 7) ? 2'b00 : 2'b01, 1'b1,
           (i < 7) ? F3 : FM1, (i == 5 || i == 11));
    check("t5_level", {29'd0, fifo_level}, 32'd0);

    // T6: reset with three results in flight; counter restarts afterwards
    do_reset();
    pair(2'b00, F1, F1, F2, 1'b0);
    pair(2'b00, F1, F1, F2, 1'b0);
    idle(6);
    repeat (4) step(1'b0, F0, 1'b1, F1, 2'b00, 1'b0, F0, 1'b0);
    repeat (3) step(1'b1, F1, 1'b0, F0, 2'b00, 1'b0, F0, 1'b0);
    reset = 1'b0;
    #1;
    check("t6_out_zero", out, F0);
    check("t6_valid_zero", {31'd0, valid_out}, 32'd0);
    check("t6_level_zero", {29'd0, fifo_level}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    idle(8);
    check("t6_level_after_release", {29'd0, fifo_level}, 32'd0);
    for (int i = 0; i < 6; i++) pair(2'b00, F1, F1, F2, (i == 5));

    w = 0;
    while (sb_q.size() != 0 && w < 50) begin
      @(posedge clk);
      w++;
    end
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
